// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_core_p slice: opcodes, FSM states and status-flag layout.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_MVR  = 4'h0,
    OP_LDB  = 4'h1,
    OP_STB  = 4'h2,
    OP_RDS  = 4'h3,
    OP_MUL  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_NOP0 = 4'h7,
    OP_NOT  = 4'h8,
    OP_AND  = 4'h9,
    OP_ORA  = 4'hA,
    OP_ADD  = 4'hB,
    OP_SUB  = 4'hC,
    OP_XOR  = 4'hD,
    OP_INC  = 4'hE,
    OP_NOP1 = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_RUN
  } state_e;

  localparam int unsigned ST_C = 0;
  localparam int unsigned ST_Z = 1;
  localparam int unsigned ST_N = 2;
  localparam int unsigned ST_V = 3;

  // Field order puts C at bit 0 so the packed value matches the ST_* indices.
  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/cpu_regfile.sv
// General register file: two combinational read ports, one synchronous write port, async clear.
module cpu_regfile #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 16,
  localparam int REG_AW   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  // NOTE: this array is reset on purpose -- the architecture defines every register as zero
  // after reset, so it must be built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      // NOTE: non-blocking, so a read of the same register this cycle still returns the old value.
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_core_p.sv
// Register CPU core: single-cycle ALU and a DATA_W-iteration shift-add multiplier.
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 16,
  localparam int REG_AW   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        status
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [REG_AW-1:0]   mul_rd_q, mul_rd_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  flags_t              status_q, status_d;

  opcode_e             op;
  logic                accept, mul_last;
  logic [DATA_W-1:0]   rs1_val, rs2_val;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v, alu_wr, alu_upd;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_step;

  assign op       = opcode_e'(opcode);
  assign accept   = instr_valid && instr_ready;
  assign mul_last = (state_q == ST_MUL_RUN) && (cnt_q == CNT_W'(DATA_W - 1));

  // One shift-add step: conditionally add the latched multiplicand to the high half, shift right.
  assign mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                   + {1'b0, (prod_q[0] ? mcand_q : {DATA_W{1'b0}})};
  assign prod_step = {mul_sum, prod_q[DATA_W-1:1]};

  cpu_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr_a_i(rs1),
    .rdata_a_o(rs1_val),
    .raddr_b_i(rs2),
    .rdata_b_o(rs2_val)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b0;
    alu_upd = 1'b0;
    case (op)
      OP_MVR: begin alu_res = rs1_val; alu_wr = 1'b1; end
      OP_LDB: begin alu_res = imm;     alu_wr = 1'b1; end
      OP_SHL: begin {alu_c, alu_res} = {rs1_val, 1'b0}; alu_wr = 1'b1; alu_upd = 1'b1; end
      OP_SHR: begin alu_res = rs1_val >> 1; alu_c = rs1_val[0]; alu_wr = 1'b1; alu_upd = 1'b1; end
      OP_NOT: begin alu_res = ~rs1_val;           alu_wr = 1'b1; alu_upd = 1'b1; end
      OP_AND: begin alu_res = rs1_val & rs2_val;  alu_wr = 1'b1; alu_upd = 1'b1; end
      OP_ORA: begin alu_res = rs1_val | rs2_val;  alu_wr = 1'b1; alu_upd = 1'b1; end
      OP_XOR: begin alu_res = rs1_val ^ rs2_val;  alu_wr = 1'b1; alu_upd = 1'b1; end
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, rs1_val} + {1'b0, rs2_val};
        alu_v   = (rs1_val[DATA_W-1] == rs2_val[DATA_W-1]) && (alu_res[DATA_W-1] != rs1_val[DATA_W-1]);
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res = rs1_val - rs2_val;
        alu_c   = rs1_val < rs2_val;
        alu_v   = (rs1_val[DATA_W-1] != rs2_val[DATA_W-1]) && (alu_res[DATA_W-1] != rs1_val[DATA_W-1]);
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_INC: begin
        alu_res = rs1_val + DATA_W'(1);
        alu_c   = &rs1_val;
        alu_v   = rs1_val == MAX_POS;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_res;
    if (mul_last) begin
      rf_we    = 1'b1;
      rf_waddr = mul_rd_q;
      rf_wdata = prod_step[DATA_W-1:0];
    end else if (accept && alu_wr) begin
      rf_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && op == OP_MUL) state_d = ST_MUL_RUN;
      ST_MUL_RUN: if (mul_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mul_rd_d   = mul_rd_q;
    data_out_d = data_out_q;
    status_d   = status_q;
    if (accept) begin
      case (op)
        OP_STB: data_out_d = rs1_val;
        OP_RDS: data_out_d = DATA_W'(status_q);
        OP_MUL: begin
          mcand_d  = rs1_val;
          prod_d   = {{DATA_W{1'b0}}, rs2_val};
          mul_rd_d = rd;
          cnt_d    = '0;
        end
        default: ;
      endcase
      if (alu_upd) status_d = '{v: alu_v, n: alu_res[DATA_W-1], z: alu_res == '0, c: alu_c};
    end else if (state_q == ST_MUL_RUN) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + CNT_W'(1);
      if (mul_last) begin
        cnt_d    = '0;
        status_d = '{v: 1'b0,
                     n: prod_step[DATA_W-1],
                     z: prod_step[DATA_W-1:0] == '0,
                     c: prod_step[2*DATA_W-1:DATA_W] != '0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      mul_rd_q   <= '0;
      data_out_q <= '0;
      status_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mul_rd_q   <= mul_rd_d;
      data_out_q <= data_out_d;
      status_q   <= status_d;
    end
  end

  assign data_out = data_out_q;
  assign status   = status_q;

endmodule
